// File: rtl/imm_encoder_pkg.sv
// Shared types for the immediate encoder: instruction formats, opcode field positions, request bundle.
// No logic; imported by imm_pack and imm_encoder.
// IMM_RANGE_CHECK_EN (optional) is consumed by imm_pack.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_S   = 2'b01,
        FMT_RSV = 2'b10,
        FMT_SB  = 2'b11
    } fmt_e;

    localparam int OPC_FMT_HI = 6;
    localparam int OPC_FMT_LO = 5;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
    } req_t;

endpackage

// File: rtl/imm_encoder_imm_pack.sv
// Packs request fields and immediate into a 32-bit I/S/SB instruction word; flags unencodable requests.
// Latency: purely combinational.
// Backpressure: none; IMM_RANGE_CHECK_EN adds immediate range/alignment checks to err.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  req_t        req,
    output logic [31:0] instr,
    output logic        err
);

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic fits12;
    logic fits13;
    logic range_bad;

    // Representable iff every bit above the sign bit replicates it.
    assign fits12 = (&req.imm[63:11]) | ~(|req.imm[63:11]);
    assign fits13 = (&req.imm[63:12]) | ~(|req.imm[63:12]);

    always_comb begin
        instr     = '0;
        err       = 1'b0;
        range_bad = 1'b0;
        case (fmt)
            FMT_I: begin
                instr     = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                range_bad = ~fits12;
            end
            FMT_S: begin
                instr     = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
                range_bad = ~fits12;
            end
            FMT_SB: begin
                instr     = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                             req.imm[4:1], req.imm[11], req.opcode};
                range_bad = ~fits13 | req.imm[0];
            end
            default: begin
                instr = '0;
                err   = 1'b1;
            end
        endcase
        err = err | (RANGE_CHECK & range_bad);
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 registers the request, S2 registers the packed word and error.
// Latency: 2 cycles accept-to-out_valid, 1 word/cycle throughput.
// Backpressure: out_ready low stalls S2 (outputs hold), then S1; in_ready drops once both are full.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    req_t        in_req;
    req_t        s1_req;
    logic        s1_valid;
    fmt_e        s1_fmt;
    logic        s1_take;
    logic        s2_take;
    logic [31:0] pk_instr;
    logic        pk_err;

    assign in_req = '{opcode: in_opcode, funct3: in_funct3, rd: in_rd,
                      rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    assign s2_take  = ~out_valid | out_ready;
    assign s1_take  = ~s1_valid | s2_take;
    assign in_ready = s1_take;

    assign s1_fmt = fmt_e'(s1_req.opcode[OPC_FMT_HI:OPC_FMT_LO]);

    imm_pack u_pack (
        .fmt   (s1_fmt),
        .req   (s1_req),
        .instr (pk_instr),
        .err   (pk_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_req    <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
        end else begin
            if (s1_take) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_req <= in_req;
                end
            end
            // Payload only moves with a valid word, so a stalled or idle S2 keeps its last value.
            if (s2_take) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= pk_instr;
                    out_err   <= pk_err;
                end
            end
            if (out_valid && out_ready) begin
                enc_count <= enc_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extractor: packs a 64-bit sign-extended immediate plus register/funct fields into a 32-bit RV64 instruction word.
- Format is selected by opcode[6:5]: 00 = I, 01 = S, 11 = SB, 10 = unsupported.
- Two-stage valid/ready pipeline. Feeds the instruction-memory loader and self-check harness that round-trips through the extractor.

Parameters:
- CNT_W, 16, width of the encoded-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request
- in_opcode  input  7  instruction opcode[6:0]; [6:5] selects format
- in_funct3  input  3  funct3 field
- in_rd  input  5  rd (I only)
- in_rs1  input  5  rs1
- in_rs2  input  5  rs2 (S/SB only)
- in_imm  input  64  sign-extended immediate (byte offset for SB)
- out_valid  output  1  instruction valid
- out_ready  input  1  consumer accepts
- out_instr  output  32  encoded instruction
- out_err  output  1  request unencodable (qualified by out_valid)
- enc_count  output  CNT_W  count of instructions delivered (out_valid && out_ready), wraps

Behaviour:
- Reset (synchronous): stage-1 valid = 0, out_valid = 0, out_instr = 0, out_err = 0, enc_count = 0. in_ready = 1 in the first cycle after reset.
- Stage 1 (S1) registers the request. Stage 2 (S2) registers the encoded word and error flag.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 per cycle.
- Advance rules:
  - s2_take = !out_valid || out_ready.
  - s1_take = !s1_valid || s2_take.
  - in_ready = s1_take (combinational from registered state and out_ready).
- Transfer occurs on valid && ready. While out_valid && !out_ready, out_instr and out_err hold stable.
- Common fields: instr[6:0] = opcode, [14:12] = funct3, [19:15] = rs1.
- I type: [31:20] = imm[11:0], [11:7] = rd.
- S type: [31:25] = imm[11:5], [24:20] = rs2, [11:7] = imm[4:0].
- SB type: [31] = imm[12], [30:25] = imm[10:5], [24:20] = rs2, [11:8] = imm[4:1], [7] = imm[11]. imm[0] is dropped.
- opcode[6:5] = 10: out_instr = 0, out_err = 1.
- rd is ignored for S/SB. rs2 is ignored for I.
- enc_count increments on each output handshake, including errored words. It wraps at 2^CNT_W − 1 → 0.
- Reset mid-transfer discards both stages. No partial output is produced.
- Simultaneous S2 drain and S1 refill in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- When defined, out_err is also set when the immediate is not representable:
  - I/S: in_imm[63:11] not all equal to in_imm[11].
  - SB: in_imm[63:12] not all equal to in_imm[12], or in_imm[0] = 1.
  - The encoded word is still produced from the truncated fields.
- When undefined, only the unsupported-format case sets out_err. Out-of-range immediates are silently truncated.

Decomposition:
- Shared package holds:
  - Format enum: FMT_I = 2'b00, FMT_S = 2'b01, FMT_SB = 2'b11, FMT_RSV = 2'b10.
  - Opcode field position constants.
- Sub-module imm_pack: purely combinational, takes format, fields and imm; returns instr[31:0] and err. Instantiated between S1 and S2.
- The top level holds the pipeline registers, handshake and counter.

Test Plan:
- I type: opcode 0010011, f3 0, rd 1, rs1 0, imm 5 → out_instr 0x00500093, out_err 0, out_valid 2 cycles after accept.
- S type: opcode 0100011, f3 3, rs1 3, rs2 2, imm 8 → 0x0021B423. SB type: opcode 1100011, f3 0, rs1 1, rs2 2, imm −4 → 0xFE208EE3.
- Backpressure: stream 4 requests with out_ready low for 3 cycles → in_ready falls after 2 accepts, out_instr holds, all 4 words delivered in order, enc_count = 4.
- Errors: opcode[6:5] = 10 → out_err 1, out_instr 0. I type with imm 2048 → err 1 with IMM_RANGE_CHECK_EN; without it, err 0 and instr[31:20] = 0x800.
- Reset asserted with both stages full → next cycle out_valid 0, enc_count 0, in_ready 1. Run 2^CNT_W + 1 transfers → enc_count = 1.
